// File: rtl/rv_cluster_mem_arbiter_if.sv
// rv_cluster_mem_arbiter_if: per-core request bus and shared memory port of the cluster arbiter
interface rv_cluster_mem_arbiter_if #(
  parameter int NCORES = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 3
);
  logic                 w_stall;
  logic [NCORES-1:0]    w_req;
  logic [NCORES*AW-1:0] w_addr;
  logic [NCORES*DW-1:0] w_wdata;
  logic [NCORES-1:0]    w_we;
  logic [NCORES*CW-1:0] w_ctrl;
  logic                 w_mem_ack;
  logic [DW-1:0]        w_mem_rdata;
  logic                 r_mem_req;
  logic [AW-1:0]        r_mem_addr;
  logic [DW-1:0]        r_mem_wdata;
  logic                 r_mem_we;
  logic [CW-1:0]        r_mem_ctrl;
  logic [NCORES-1:0]    r_grant;
  logic [NCORES-1:0]    r_done;
  logic [DW-1:0]        r_rdata;
  logic                 r_busy;
  modport slave (
    input  w_stall, w_req, w_addr, w_wdata, w_we, w_ctrl, w_mem_ack, w_mem_rdata,
    output r_mem_req, r_mem_addr, r_mem_wdata, r_mem_we, r_mem_ctrl, r_grant, r_done, r_rdata, r_busy
  );
  modport master (
    output w_stall, w_req, w_addr, w_wdata, w_we, w_ctrl, w_mem_ack, w_mem_rdata,
    input  r_mem_req, r_mem_addr, r_mem_wdata, r_mem_we, r_mem_ctrl, r_grant, r_done, r_rdata, r_busy
  );
endinterface

// File: rtl/rv_cluster_mem_arbiter.sv
// rv_cluster_mem_arbiter: round-robin arbiter serialising per-core memory requests onto one port
module rv_cluster_mem_arbiter #(
  parameter int NCORES = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 3
) (
  input logic CLK,
  input logic RST_X,
  rv_cluster_mem_arbiter_if.slave bus
);
  localparam int PW = NCORES > 1 ? $clog2(NCORES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t st, nxt;
  logic [PW-1:0] ptr, gidx, pick, ptr_nxt;
  logic [NCORES-1:0] pick_oh;
  logic pick_vld, ack_ok, issue, fin;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic sel_we;
  logic [CW-1:0] sel_ctrl;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NCORES);
  endfunction
  // lowest rotation distance from the pointer wins, so scan from the far end down
  always_comb begin
    pick_vld = 1'b0;
    pick = '0;
    pick_oh = '0;
    for (int k = NCORES - 1; k >= 0; k--)
      if (bus.w_req[wrap(int'(ptr) + k)]) begin
        pick_vld = 1'b1;
        pick = wrap(int'(ptr) + k);
      end
    pick_oh[pick] = pick_vld;
  end
  always_comb begin
    sel_addr = '0;
    sel_wdata = '0;
    sel_we = 1'b0;
    sel_ctrl = '0;
    for (int i = 0; i < NCORES; i++)
      if (pick == PW'(i)) begin
        sel_addr = bus.w_addr[i*AW +: AW];
        sel_wdata = bus.w_wdata[i*DW +: DW];
        sel_we = bus.w_we[i];
        sel_ctrl = bus.w_ctrl[i*CW +: CW];
      end
  end
  // the issue cycle itself still shows r_mem_req, so an ack there is too early
  assign ack_ok = bus.w_mem_ack && !bus.r_mem_req;
  assign issue = st == IDLE && pick_vld;
  assign fin = st == WAIT && ack_ok;
  assign ptr_nxt = gidx == PW'(NCORES - 1) ? '0 : gidx + 1'b1;
  assign bus.r_busy = st != IDLE;
  always_comb nxt = st == IDLE ? (pick_vld ? WAIT : IDLE) : st == WAIT ? (ack_ok ? DONE : WAIT) : IDLE;
  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X) st <= IDLE;
    else if (!bus.w_stall) st <= nxt;
  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X) begin
      ptr <= '0;
      gidx <= '0;
      bus.r_mem_req <= 1'b0;
      bus.r_mem_addr <= '0;
      bus.r_mem_wdata <= '0;
      bus.r_mem_we <= 1'b0;
      bus.r_mem_ctrl <= '0;
      bus.r_grant <= '0;
      bus.r_done <= '0;
      bus.r_rdata <= '0;
    end else if (!bus.w_stall) begin
      bus.r_mem_req <= issue;
      bus.r_done <= fin ? bus.r_grant : '0;
      if (issue) begin
        gidx <= pick;
        bus.r_grant <= pick_oh;
        bus.r_mem_addr <= sel_addr;
        bus.r_mem_wdata <= sel_wdata;
        bus.r_mem_we <= sel_we;
        bus.r_mem_ctrl <= sel_ctrl;
      end
      if (fin) bus.r_rdata <= bus.w_mem_rdata;
      if (st == DONE) begin
        bus.r_grant <= '0;
        ptr <= ptr_nxt;
      end
    end
endmodule

// File: tb/tb_rv_cluster_mem_arbiter.sv
// tb_rv_cluster_mem_arbiter: scenario tasks plus randomized traffic against a round-robin reference model
module tb_rv_cluster_mem_arbiter;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  int checks = 0;
  int errors = 0;
  int mptr = 0;
  rv_cluster_mem_arbiter_if #(.NCORES(N), .AW(AW), .DW(DW), .CW(CW)) bus ();
  rv_cluster_mem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .CW(CW)) dut (.CLK(clk), .RST_X(rst_x), .bus(bus));
  always #5 clk = ~clk;

  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      ok = bus.r_mem_req;
    end
  endtask

  task automatic ack_after(input int lat, input logic [DW-1:0] d);
    repeat (lat) tick();
    bus.w_mem_ack = 1'b1;
    bus.w_mem_rdata = d;
    tick();
    bus.w_mem_ack = 1'b0;
  endtask

  task automatic set_core(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we, input logic [CW-1:0] ct);
    bus.w_addr[c*AW +: AW] = a;
    bus.w_wdata[c*DW +: DW] = d;
    bus.w_we[c] = we;
    bus.w_ctrl[c*CW +: CW] = ct;
  endtask

  task automatic test_reset();
    rst_x = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.r_mem_req, bus.r_grant, bus.r_done, bus.r_busy, bus.r_mem_we} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b grant=%b done=%b busy=%b we=%b exp all 0", bus.r_mem_req, bus.r_grant, bus.r_done, bus.r_busy, bus.r_mem_we);
    end
    checks++;
    if ({bus.r_mem_addr, bus.r_mem_wdata, bus.r_rdata, bus.r_mem_ctrl} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h ctrl=%h exp 0", bus.r_mem_addr, bus.r_mem_wdata, bus.r_rdata, bus.r_mem_ctrl);
    end
    rst_x = 1'b1;
    mptr = 0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    set_core(0, 32'h8000_1000, 32'h0, 1'b0, 3'd2);
    bus.w_req = 4'b0001;
    wait_issue(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_issue got no r_mem_req exp pulse");
      return;
    end
    checks++;
    if (bus.r_mem_addr !== 32'h8000_1000 || bus.r_mem_we !== 1'b0 || bus.r_grant !== 4'b0001 || bus.r_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_fields got addr=%h we=%b grant=%b busy=%b exp 80001000 0 0001 1", bus.r_mem_addr, bus.r_mem_we, bus.r_grant, bus.r_busy);
    end
    ack_after(4, 32'hDEAD_BEEF);
    checks++;
    if (bus.r_done !== 4'b0001 || bus.r_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_done got done=%b rdata=%h exp 0001 deadbeef", bus.r_done, bus.r_rdata);
    end
    bus.w_req = '0;
    tick();
    checks++;
    if (bus.r_done !== '0 || bus.r_grant !== '0 || bus.r_busy !== 1'b0 || bus.r_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_after got done=%b grant=%b busy=%b rdata=%h exp 0000 0000 0 deadbeef", bus.r_done, bus.r_grant, bus.r_busy, bus.r_rdata);
    end
    mptr = 1;
  endtask

  task automatic test_fairness();
    bit ok;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] d;
    test_reset();
    bus.w_req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_issue(ok);
      checks++;
      if (!ok || bus.r_grant !== 4'(1 << exp_order[t])) begin
        errors++;
        $display("FAIL fair_grant%0d got ok=%b grant=%b exp core %0d", t, ok, bus.r_grant, exp_order[t]);
      end
      d = $urandom;
      ack_after(2, d);
      checks++;
      if (bus.r_done !== 4'(1 << exp_order[t]) || bus.r_rdata !== d) begin
        errors++;
        $display("FAIL fair_done%0d got done=%b rdata=%h exp core %0d rdata=%h", t, bus.r_done, bus.r_rdata, exp_order[t], d);
      end
      mptr = (exp_order[t] + 1) % N;
    end
    bus.w_req = '0;
    tick();
  endtask

  task automatic test_write_latch();
    bit ok;
    set_core(1, 32'h10, 32'h1234_5678, 1'b1, 3'd5);
    bus.w_req = 4'b0010;
    wait_issue(ok);
    bus.w_wdata = '0;
    bus.w_we = '0;
    bus.w_addr = '0;
    tick();
    checks++;
    if (!ok || bus.r_mem_wdata !== 32'h1234_5678 || bus.r_mem_we !== 1'b1 || bus.r_mem_addr !== 32'h10 || bus.r_mem_ctrl !== 3'd5) begin
      errors++;
      $display("FAIL wlatch_held got ok=%b wdata=%h we=%b addr=%h ctrl=%0d exp 12345678 1 10 5", ok, bus.r_mem_wdata, bus.r_mem_we, bus.r_mem_addr, bus.r_mem_ctrl);
    end
    ack_after(1, 32'h0);
    bus.w_req = '0;
    repeat (2) tick();
    checks++;
    if (bus.r_mem_wdata !== 32'h1234_5678 || bus.r_mem_we !== 1'b1) begin
      errors++;
      $display("FAIL wlatch_idle got wdata=%h we=%b exp 12345678 1", bus.r_mem_wdata, bus.r_mem_we);
    end
    mptr = 2;
  endtask

  task automatic test_stall();
    bit ok;
    int done_seen = 0;
    bus.w_req = 4'b1000;
    wait_issue(ok);
    tick();
    bus.w_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.w_mem_ack = i == 2;
      tick();
      checks++;
      if (bus.r_busy !== 1'b1 || bus.r_grant !== 4'b1000 || bus.r_done !== '0 || bus.r_mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got busy=%b grant=%b done=%b req=%b exp 1 1000 0000 0", i, bus.r_busy, bus.r_grant, bus.r_done, bus.r_mem_req);
      end
    end
    bus.w_mem_ack = 1'b0;
    bus.w_stall = 1'b0;
    bus.w_req = '0;
    ack_after(0, 32'hCAFE_0003);
    for (int i = 0; i < 3; i++) begin
      if (bus.r_done == 4'b1000) done_seen++;
      tick();
    end
    checks++;
    if (done_seen != 1 || bus.r_rdata !== 32'hCAFE_0003) begin
      errors++;
      $display("FAIL stall_done got pulses=%0d rdata=%h exp 1 cafe0003", done_seen, bus.r_rdata);
    end
    mptr = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.w_req = 4'b0010;
    wait_issue(ok);
    ack_after(1, 32'h1);
    bus.w_req = 4'b0100;
    wait_issue(ok);
    tick();
    rst_x = 1'b0;
    bus.w_req = '0;
    #1;
    checks++;
    if ({bus.r_grant, bus.r_busy, bus.r_mem_req, bus.r_done, bus.r_mem_addr, bus.r_rdata} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear got grant=%b busy=%b req=%b done=%b addr=%h rdata=%h exp all 0", bus.r_grant, bus.r_busy, bus.r_mem_req, bus.r_done, bus.r_mem_addr, bus.r_rdata);
    end
    #2 rst_x = 1'b1;
    tick();
    bus.w_mem_ack = 1'b1;
    tick();
    bus.w_mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.r_done !== '0 || bus.r_busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stray%0d got done=%b busy=%b exp 0000 0", i, bus.r_done, bus.r_busy);
      end
    end
    mptr = 0;
    bus.w_req = 4'b0101;
    wait_issue(ok);
    checks++;
    if (!ok || bus.r_grant !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_regrant got ok=%b grant=%b exp 0001", ok, bus.r_grant);
    end
    ack_after(1, 32'h2);
    bus.w_req = '0;
    tick();
    mptr = 1;
  endtask

  task automatic test_early_ack();
    bit ok;
    bus.w_req = 4'b0100;
    wait_issue(ok);
    bus.w_mem_ack = 1'b1;
    bus.w_mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.w_mem_ack = 1'b0;
    tick();
    checks++;
    if (!ok || bus.r_busy !== 1'b1 || bus.r_done !== '0) begin
      errors++;
      $display("FAIL early_ignored got ok=%b busy=%b done=%b exp 1 1 0000", ok, bus.r_busy, bus.r_done);
    end
    bus.w_req = '0;
    ack_after(1, 32'h600D_600D);
    checks++;
    if (bus.r_done !== 4'b0100 || bus.r_rdata !== 32'h600D_600D) begin
      errors++;
      $display("FAIL early_dropdone got done=%b rdata=%h exp 0100 600d600d", bus.r_done, bus.r_rdata);
    end
    tick();
    mptr = 3;
  endtask

  task automatic test_random();
    bit ok;
    logic [N-1:0] m;
    logic [AW-1:0] ea[N];
    logic [DW-1:0] ed[N];
    logic [CW-1:0] ec[N];
    logic [N-1:0] ew;
    logic [DW-1:0] d;
    int w;
    for (int t = 0; t < 30; t++) begin
      for (int c = 0; c < N; c++) begin
        ea[c] = $urandom;
        ed[c] = $urandom;
        ec[c] = CW'($urandom);
        ew[c] = 1'($urandom);
        set_core(c, ea[c], ed[c], ew[c], ec[c]);
      end
      m = N'($urandom_range(1, (1 << N) - 1));
      bus.w_req = m;
      w = model_pick(m);
      wait_issue(ok);
      for (int c = 0; c < N; c++) set_core(c, $urandom, $urandom, 1'($urandom), CW'($urandom));
      checks++;
      if (!ok || bus.r_grant !== 4'(1 << w) || bus.r_mem_addr !== ea[w] || bus.r_mem_wdata !== ed[w] || bus.r_mem_we !== ew[w] || bus.r_mem_ctrl !== ec[w]) begin
        errors++;
        $display("FAIL rand_issue%0d got grant=%b addr=%h wdata=%h we=%b ctrl=%0d exp core %0d addr=%h wdata=%h we=%b ctrl=%0d", t, bus.r_grant, bus.r_mem_addr, bus.r_mem_wdata, bus.r_mem_we, bus.r_mem_ctrl, w, ea[w], ed[w], ew[w], ec[w]);
      end
      d = $urandom;
      ack_after($urandom_range(1, 4), d);
      checks++;
      if (bus.r_done !== 4'(1 << w) || bus.r_rdata !== d) begin
        errors++;
        $display("FAIL rand_done%0d got done=%b rdata=%h exp core %0d rdata=%h", t, bus.r_done, bus.r_rdata, w, d);
      end
      mptr = (w + 1) % N;
    end
    bus.w_req = '0;
    tick();
  endtask

  initial begin
    bus.w_stall = 1'b0;
    bus.w_req = '0;
    bus.w_addr = '0;
    bus.w_wdata = '0;
    bus.w_we = '0;
    bus.w_ctrl = '0;
    bus.w_mem_ack = 1'b0;
    bus.w_mem_rdata = '0;
    test_reset();
    test_single();
    test_fairness();
    test_write_latch();
    test_stall();
    test_reset_mid();
    test_early_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
